// File: rtl/spi_pkg.sv
// Shared SPI write-link definitions: frame geometry, register map and controller state encoding.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 16;
  localparam int unsigned SPI_ADDR_W  = 7;
  localparam int unsigned SPI_DATA_W  = 8;
  localparam int unsigned SPI_PHASES  = 2 * SPI_FRAME_W;
  localparam int unsigned SPI_PHASE_W = 5;
  localparam int unsigned SPI_DIV_W   = 8;

  localparam logic [SPI_ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_ctrl_state_t;

  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running DIV-cycle tick generator; held at zero while cleared.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam logic [SPI_DIV_W-1:0] LAST = SPI_DIV_W'(DIV - 1);

  logic [SPI_DIV_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + SPI_DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI Mode-0 write initiator: serialises {rw, addr, data} MSB first with setup, hold and nCS gap.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              copi,
  output logic              ncs
);

  localparam logic [SPI_PHASE_W-1:0] LAST_PHASE = SPI_PHASE_W'(SPI_PHASES - 1);

  spi_ctrl_state_t r_state, w_state_nxt;

  logic [SPI_FRAME_W-1:0] r_sr, w_sr_nxt;
  logic [SPI_PHASE_W-1:0] r_phase, w_phase_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_sclk, w_sclk_nxt;
  logic r_copi, w_copi_nxt;
  logic r_ncs, w_ncs_nxt;

  logic       w_accept;
  logic       w_tick;
  logic       w_clr;
  spi_frame_t w_frame_in;

  assign w_frame_in = '{rw: rw, addr: SPI_ADDR_W'(addr), data: SPI_DATA_W'(wdata)};

  // Divider restarts on accept so the first SETUP cycle is count 0.
  assign w_clr = w_accept || (r_state == ST_IDLE);

  spi_clk_div #(
    .DIV(CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .o_tick_c(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_phase <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sclk  <= w_sclk_nxt;
      r_copi  <= w_copi_nxt;
      r_ncs   <= w_ncs_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_phase_nxt = r_phase;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sclk_nxt  = r_sclk;
    w_copi_nxt  = r_copi;
    w_ncs_nxt   = r_ncs;
    w_accept    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_accept = start;
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
          w_phase_nxt = '0;
        end
      end
      ST_SHIFT: begin
        // Even phases are low, odd phases high; data advances only on falling edges.
        if (w_tick) begin
          if (r_phase == LAST_PHASE) begin
            w_state_nxt = ST_HOLD;
            w_sclk_nxt  = 1'b0;
          end else begin
            w_phase_nxt = r_phase + SPI_PHASE_W'(1);
            w_sclk_nxt  = ~r_phase[0];
            if (r_phase[0]) begin
              w_sr_nxt   = {r_sr[SPI_FRAME_W-2:0], 1'b0};
              w_copi_nxt = r_sr[SPI_FRAME_W-2];
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_state_nxt = ST_GAP;
          w_ncs_nxt   = 1'b1;
          w_copi_nxt  = 1'b0;
        end
      end
      ST_GAP: begin
        // The edge that raises done may also take the next request, giving a 35*D period.
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_accept    = start;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_copi_nxt  = 1'b0;
        w_ncs_nxt   = 1'b1;
      end
    endcase

    if (w_accept) begin
      w_state_nxt = ST_SETUP;
      w_sr_nxt    = w_frame_in;
      w_phase_nxt = '0;
      w_busy_nxt  = 1'b1;
      w_sclk_nxt  = 1'b0;
      w_copi_nxt  = w_frame_in.rw;
      w_ncs_nxt   = 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sclk = r_sclk;
  assign copi = r_copi;
  assign ncs  = r_ncs;

endmodule
